// File: rtl/gate_array_pipelined.sv
// Run-time selectable array of 2-input gates with valid-tagged pipeline and a saturating
// output-activity counter. Defaults to NAND so it drops in for the quad NAND part.
module gate_array_pipelined #(
    parameter int unsigned CHANNELS    = 4,
    parameter int unsigned PIPE_STAGES = 1,
    parameter int unsigned CNT_W       = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [CHANNELS-1:0] A,
    input  logic [CHANNELS-1:0] B,
    input  logic                in_valid,
    input  logic [2:0]          func_sel,
    input  logic                func_load,
    input  logic                cnt_clr,
    output logic [CHANNELS-1:0] Y,
    output logic                out_valid,
    output logic [2:0]          func_cur,
    output logic                func_err,
    output logic [CNT_W-1:0]    act_cnt
);

    typedef enum logic [2:0] {
        FnNand = 3'd0,
        FnAnd  = 3'd1,
        FnNor  = 3'd2,
        FnOr   = 3'd3,
        FnXor  = 3'd4,
        FnXnor = 3'd5
    } func_e;

    func_e               func_q, func_d;
    logic                func_err_q, func_err_d;
    logic [CHANNELS-1:0] gate_y;
    logic [CHANNELS-1:0] y_prev_q, y_prev_d;
    logic [CNT_W-1:0]    act_cnt_q, act_cnt_d;

    // Element 0 is the stage-0 input; element s+1 is the output of stage s.
    logic [CHANNELS-1:0] stg_data [PIPE_STAGES+1];
    logic                stg_vld  [PIPE_STAGES+1];

    // Function register: illegal codes are rejected and flagged for one cycle.
    always_comb begin
        func_d     = func_q;
        func_err_d = 1'b0;
        if (func_load) begin
            if (func_sel <= 3'd5) begin
                func_d = func_e'(func_sel);
            end else begin
                func_err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            func_q     <= FnNand;
            func_err_q <= 1'b0;
        end else begin
            func_q     <= func_d;
            func_err_q <= func_err_d;
        end
    end

    // Evaluated with the pre-edge function, so a simultaneous load only affects later samples.
    always_comb begin
        unique case (func_q)
            FnNand:  gate_y = ~(A & B);
            FnAnd:   gate_y = A & B;
            FnNor:   gate_y = ~(A | B);
            FnOr:    gate_y = A | B;
            FnXor:   gate_y = A ^ B;
            FnXnor:  gate_y = ~(A ^ B);
            default: gate_y = ~(A & B);
        endcase
    end

    assign stg_data[0] = gate_y;
    assign stg_vld[0]  = in_valid;

    for (genvar s = 0; s < PIPE_STAGES; s++) begin : g_stage
        logic [CHANNELS-1:0] data_q, data_d;
        logic                vld_q, vld_d;

        // Data only moves with a valid beat, so bubbles leave every stage (and Y) untouched.
        always_comb begin
            vld_d  = stg_vld[s];
            data_d = stg_vld[s] ? stg_data[s] : data_q;
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                data_q <= '0;
                vld_q  <= 1'b0;
            end else begin
                data_q <= data_d;
                vld_q  <= vld_d;
            end
        end

        assign stg_data[s+1] = data_q;
        assign stg_vld[s+1]  = vld_q;
    end

    assign Y         = stg_data[PIPE_STAGES];
    assign out_valid = stg_vld[PIPE_STAGES];

    // Clear beats a simultaneous increment; y_prev tracks every valid beat regardless.
    always_comb begin
        act_cnt_d = act_cnt_q;
        y_prev_d  = y_prev_q;
        if (out_valid) begin
            y_prev_d = Y;
        end
        if (cnt_clr) begin
            act_cnt_d = '0;
        end else if (out_valid && (Y != y_prev_q) && (act_cnt_q != {CNT_W{1'b1}})) begin
            act_cnt_d = act_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            act_cnt_q <= '0;
            y_prev_q  <= '0;
        end else begin
            act_cnt_q <= act_cnt_d;
            y_prev_q  <= y_prev_d;
        end
    end

    assign func_cur = func_q;
    assign func_err = func_err_q;
    assign act_cnt  = act_cnt_q;

endmodule

// File: tb/tb_gate_array_pipelined.sv
// Randomised and directed bench for gate_array_pipelined; three instances with latencies
// 1, 3 and 4 share stimulus and are checked against a cycle-indexed reference model.
module tb_gate_array_pipelined;

    logic       clk;
    logic       rst_n;
    logic [3:0] a;
    logic [3:0] b;
    logic       in_valid;
    logic [2:0] func_sel;
    logic       func_load;
    logic       cnt_clr;

    logic [3:0]  y1, y3, y4;
    logic        ov1, ov3, ov4;
    logic [2:0]  fc1, fc3, fc4;
    logic        fe1, fe3, fe4;
    logic [15:0] c1;
    logic [3:0]  c3;
    logic [15:0] c4;

    int n_checks = 0;
    int n_errors = 0;

    gate_array_pipelined #(.CHANNELS(4), .PIPE_STAGES(1), .CNT_W(16)) u_p1 (
        .clk(clk), .rst_n(rst_n), .A(a), .B(b), .in_valid(in_valid), .func_sel(func_sel),
        .func_load(func_load), .cnt_clr(cnt_clr), .Y(y1), .out_valid(ov1), .func_cur(fc1),
        .func_err(fe1), .act_cnt(c1)
    );

    gate_array_pipelined #(.CHANNELS(4), .PIPE_STAGES(3), .CNT_W(4)) u_p3 (
        .clk(clk), .rst_n(rst_n), .A(a), .B(b), .in_valid(in_valid), .func_sel(func_sel),
        .func_load(func_load), .cnt_clr(cnt_clr), .Y(y3), .out_valid(ov3), .func_cur(fc3),
        .func_err(fe3), .act_cnt(c3)
    );

    gate_array_pipelined #(.CHANNELS(4), .PIPE_STAGES(4), .CNT_W(16)) u_p4 (
        .clk(clk), .rst_n(rst_n), .A(a), .B(b), .in_valid(in_valid), .func_sel(func_sel),
        .func_load(func_load), .cnt_clr(cnt_clr), .Y(y4), .out_valid(ov4), .func_cur(fc4),
        .func_err(fe4), .act_cnt(c4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: results indexed by the edge at which the sample was accepted.
    localparam int HistDepth = 2048;
    bit         acc_v [HistDepth];
    logic [3:0] acc_y [HistDepth];
    int         lat  [3] = '{1, 3, 4};
    int         cmax [3] = '{65535, 15, 65535};
    logic [3:0] exp_y   [3];
    bit         exp_v   [3];
    logic [3:0] yprev   [3];
    int         exp_cnt [3];
    int         func_m;
    bit         exp_err;
    int         edge_n;
    int         rst_base;

    function automatic logic [3:0] gate_ref(input int code, input logic [3:0] x,
                                            input logic [3:0] z);
        logic [3:0] r;
        for (int i = 0; i < 4; i++) begin
            int ones;
            ones = int'(x[i]) + int'(z[i]);
            case (code)
                0:       r[i] = (ones != 2);
                1:       r[i] = (ones == 2);
                2:       r[i] = (ones == 0);
                3:       r[i] = (ones != 0);
                4:       r[i] = (ones == 1);
                5:       r[i] = (ones != 1);
                default: r[i] = 1'bx;
            endcase
        end
        return r;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        func_m   = 0;
        exp_err  = 1'b0;
        rst_base = edge_n;
        for (int d = 0; d < 3; d++) begin
            exp_y[d]   = '0;
            exp_v[d]   = 1'b0;
            yprev[d]   = '0;
            exp_cnt[d] = 0;
        end
    endtask

    task automatic check_dut(input string nm, input int d, input logic [3:0] y, input logic ov,
                             input logic [2:0] fc, input logic fe, input logic [31:0] cnt);
        check_eq({nm, ".y"}, 32'(y), 32'(exp_y[d]));
        check_eq({nm, ".out_valid"}, 32'(ov), 32'(exp_v[d]));
        check_eq({nm, ".func_cur"}, 32'(fc), 32'(func_m));
        check_eq({nm, ".func_err"}, 32'(fe), 32'(exp_err));
        check_eq({nm, ".act_cnt"}, cnt, 32'(exp_cnt[d]));
    endtask

    task automatic check_all();
        check_dut("p1", 0, y1, ov1, fc1, fe1, 32'(c1));
        check_dut("p3", 1, y3, ov3, fc3, fe3, 32'(c3));
        check_dut("p4", 2, y4, ov4, fc4, fe4, 32'(c4));
    endtask

    task automatic check_reset_zero(input string nm);
        check_eq({nm, ".p1"}, {y1, ov1, fc1, fe1, c1}, 32'd0);
        check_eq({nm, ".p3"}, {y3, ov3, fc3, fe3, c3}, 32'd0);
        check_eq({nm, ".p4"}, {y4, ov4, fc4, fe4, c4}, 32'd0);
    endtask

    // One clock: advance the model with the current inputs, then compare after the edge.
    task automatic tick();
        int idx;
        if (edge_n >= HistDepth) begin
            $display("FAIL history_bound: got %0d expected below %0d", edge_n, HistDepth);
            $fatal(1, "model history exhausted");
        end
        for (int d = 0; d < 3; d++) begin
            if (cnt_clr) exp_cnt[d] = 0;
            else if (exp_v[d] && exp_y[d] != yprev[d] && exp_cnt[d] < cmax[d]) exp_cnt[d]++;
            if (exp_v[d]) yprev[d] = exp_y[d];
        end
        acc_v[edge_n] = in_valid;
        acc_y[edge_n] = gate_ref(func_m, a, b);
        exp_err = func_load && (func_sel > 3'd5);
        if (func_load && func_sel <= 3'd5) func_m = int'(func_sel);
        @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            idx = edge_n - lat[d] + 1;
            if (idx >= rst_base && acc_v[idx]) begin
                exp_v[d] = 1'b1;
                exp_y[d] = acc_y[idx];
            end else begin
                exp_v[d] = 1'b0;
            end
        end
        edge_n++;
        check_all();
    endtask

    task automatic drive(input logic [3:0] na, input logic [3:0] nb, input logic nv,
                         input logic nl, input logic [2:0] ns, input logic nc);
        a = na; b = nb; in_valid = nv; func_load = nl; func_sel = ns; cnt_clr = nc;
    endtask

    logic [3:0] sweep_exp [6] = '{4'b0111, 4'b1000, 4'b0001, 4'b1110, 4'b0110, 4'b1001};

    initial begin
        edge_n = 0;
        model_reset();
        rst_n = 1'b0;
        drive(4'h0, 4'h0, 1'b0, 1'b0, 3'd0, 1'b0);
        #2;
        check_reset_zero("reset_init");
        #5;
        rst_n = 1'b1;

        // Default NAND right out of reset
        drive(4'b1100, 4'b1010, 1'b1, 1'b0, 3'd0, 1'b0);
        tick();
        check_eq("tp_nand_y", 32'(y1), 32'(4'b0111));
        check_eq("tp_nand_ov", 32'(ov1), 32'd1);
        drive(4'b1100, 4'b1010, 1'b0, 1'b0, 3'd0, 1'b0);
        tick();

        // Function sweep
        for (int code = 0; code < 6; code++) begin
            drive(4'b1100, 4'b1010, 1'b0, 1'b1, 3'(code), 1'b0);
            tick();
            check_eq("sweep_func_cur", 32'(fc1), 32'(code));
            drive(4'b1100, 4'b1010, 1'b1, 1'b0, 3'd0, 1'b0);
            tick();
            check_eq("sweep_y", 32'(y1), 32'(sweep_exp[code]));
        end
        drive(4'b1100, 4'b1010, 1'b0, 1'b1, 3'd7, 1'b0);
        tick();
        check_eq("illegal_err_pulse", 32'(fe1), 32'd1);
        check_eq("illegal_func_kept", 32'(fc1), 32'd5);
        drive(4'b1100, 4'b1010, 1'b0, 1'b0, 3'd0, 1'b0);
        tick();
        check_eq("illegal_err_clear", 32'(fe1), 32'd0);
        check_eq("illegal_y_kept", 32'(y1), 32'(4'b1001));

        // Mid-stream switch to NOR on the third sample
        drive(4'h0, 4'h0, 1'b0, 1'b1, 3'd0, 1'b0);
        tick();
        for (int i = 0; i < 5; i++) begin
            drive(4'($urandom), 4'($urandom), 1'b1, (i == 2), 3'd2, 1'b0);
            tick();
        end
        for (int i = 0; i < 4; i++) begin
            drive(4'h0, 4'h0, 1'b0, 1'b0, 3'd0, 1'b0);
            tick();
        end

        // Bubbles: 1,0,0,1
        for (int i = 0; i < 8; i++) begin
            drive(4'($urandom), 4'($urandom), (i == 0 || i == 3), 1'b0, 3'd0, 1'b0);
            tick();
        end

        // Counter saturation with alternating operands under NAND
        drive(4'h0, 4'hf, 1'b0, 1'b1, 3'd0, 1'b0);
        tick();
        for (int i = 0; i < 20; i++) begin
            drive((i % 2 == 0) ? 4'h0 : 4'hf, 4'hf, 1'b1, 1'b0, 3'd0, 1'b0);
            tick();
        end
        for (int i = 0; i < 4; i++) begin
            drive(4'h0, 4'hf, 1'b0, 1'b0, 3'd0, 1'b0);
            tick();
        end
        check_eq("cnt_saturated", 32'(c3), 32'd15);
        for (int i = 0; i < 2; i++) begin
            drive((i % 2 == 0) ? 4'hf : 4'h0, 4'hf, 1'b1, 1'b0, 3'd0, 1'b0);
            tick();
        end
        drive(4'hf, 4'hf, 1'b1, 1'b0, 3'd0, 1'b1);
        tick();
        check_eq("cnt_clr_wins_p1", 32'(c1), 32'd0);
        check_eq("cnt_clr_wins_p3", 32'(c3), 32'd0);

        // Randomised traffic
        for (int i = 0; i < 300; i++) begin
            drive(4'($urandom), 4'($urandom), ($urandom_range(3, 0) != 0),
                  ($urandom_range(7, 0) == 0), 3'($urandom), ($urandom_range(15, 0) == 0));
            tick();
        end

        // Asynchronous reset with samples in flight
        drive(4'h0, 4'h0, 1'b0, 1'b1, 3'd3, 1'b0);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(4'($urandom), 4'($urandom), 1'b1, 1'b0, 3'd0, 1'b0);
            tick();
        end
        drive(4'h0, 4'h0, 1'b0, 1'b0, 3'd0, 1'b0);
        rst_n = 1'b0;
        #1;
        check_reset_zero("reset_midop");
        model_reset();
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            check_eq("no_valid_after_reset", 32'({ov1, ov3, ov4}), 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
